// File: rtl/register_file_sb.sv
// Parametrised register file with two combinational read ports, one clocked
// write port, optional write-to-read bypass and a pending-write scoreboard.
module register_file_sb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter bit          BYPASS     = 1'b1,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic                  clock_in,
  input  logic                  reset_n,
  input  logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] writeReg,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic [ADDR_WIDTH-1:0] readReg1,
  input  logic [ADDR_WIDTH-1:0] readReg2,
  input  logic                  resvEn,
  input  logic [ADDR_WIDTH-1:0] resvReg,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  output logic                  readBusy1,
  output logic                  readBusy2,
  output logic                  resvConflict,
  output logic [ADDR_WIDTH:0]   pendingCount
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      pending_q;
  logic [DEPTH-1:0]      pending_d;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   count_d;

  logic wr_allowed;
  logic byp1;
  logic byp2;
  logic zero1;
  logic zero2;

  assign wr_allowed = regWrite && !(ZERO_REG && (writeReg == '0));
  assign byp1  = BYPASS && regWrite && (writeReg == readReg1);
  assign byp2  = BYPASS && regWrite && (writeReg == readReg2);
  assign zero1 = ZERO_REG && (readReg1 == '0);
  assign zero2 = ZERO_REG && (readReg2 == '0);

  // Reserve is applied after the write release so a same-edge reserve wins.
  always_comb begin
    pending_d = pending_q;
    if (regWrite) pending_d[writeReg] = 1'b0;
    if (resvEn)   pending_d[resvReg]  = 1'b1;
    if (ZERO_REG) pending_d[0]        = 1'b0;
    if (!reset_n) pending_d           = '0;
  end

  always_comb begin
    count_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      count_d = count_d + (ADDR_WIDTH + 1)'(pending_d[i]);
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_allowed) begin
      mem_q[writeReg] <= writeData;
    end
  end

  always_ff @(posedge clock_in) begin
    pending_q <= pending_d;
    count_q   <= count_d;
  end

  always_comb begin
    readData1    = '0;
    readData2    = '0;
    readBusy1    = 1'b0;
    readBusy2    = 1'b0;
    resvConflict = 1'b0;
    if (reset_n) begin
      if (!zero1) begin
        readData1 = byp1 ? writeData : mem_q[readReg1];
        readBusy1 = pending_q[readReg1] & ~byp1;
      end
      if (!zero2) begin
        readData2 = byp2 ? writeData : mem_q[readReg2];
        readBusy2 = pending_q[readReg2] & ~byp2;
      end
      resvConflict = resvEn & pending_q[resvReg];
    end
  end

  assign pendingCount = count_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Directed self-checking bench for register_file_sb with BYPASS=1, ZERO_REG=1.
module tb_register_file_sb;

  logic        clock_in = 1'b0;
  logic        reset_n;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic        resvEn;
  logic [4:0]  resvReg;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic        readBusy1;
  logic        readBusy2;
  logic        resvConflict;
  logic [5:0]  pendingCount;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock_in = ~clock_in;

  register_file_sb #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .BYPASS(1'b1),
    .ZERO_REG(1'b1)
  ) dut (
    .clock_in(clock_in),
    .reset_n(reset_n),
    .regWrite(regWrite),
    .writeReg(writeReg),
    .writeData(writeData),
    .readReg1(readReg1),
    .readReg2(readReg2),
    .resvEn(resvEn),
    .resvReg(resvReg),
    .readData1(readData1),
    .readData2(readData2),
    .readBusy1(readBusy1),
    .readBusy2(readBusy2),
    .resvConflict(resvConflict),
    .pendingCount(pendingCount)
  );

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic idle();
    regWrite  = 1'b0;
    writeReg  = '0;
    writeData = '0;
    resvEn    = 1'b0;
    resvReg   = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    readReg1 = 5'd1;
    readReg2 = 5'd2;
    tick();
    #1;
    n_checks++;
    if (readData1 !== 32'h0 || readBusy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_forced: data1=%h busy1=%b required 0/0", readData1, readBusy1);
    end
    n_checks++;
    if (pendingCount !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d required 0", pendingCount);
    end
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      readReg1 = 5'(i);
      readReg2 = 5'(31 - i);
      #1;
      n_checks++;
      if (readData1 !== 32'h0 || readData2 !== 32'h0 || readBusy1 !== 1'b0 || readBusy2 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_read[%0d]: d1=%h d2=%h b1=%b b2=%b required all 0",
                 i, readData1, readData2, readBusy1, readBusy2);
      end
    end
  endtask

  task automatic test_write();
    regWrite  = 1'b1;
    writeReg  = 5'd21;
    writeData = 32'hFFFF0000;
    readReg1  = 5'd21;
    readReg2  = 5'd10;
    #1;
    n_checks++;
    if (readData1 !== 32'hFFFF0000 || readData2 !== 32'h0) begin
      n_fail++;
      $display("FAIL write_bypass_r21: d1=%h d2=%h required ffff0000/0", readData1, readData2);
    end
    tick();
    writeReg  = 5'd10;
    writeData = 32'h0000FFFF;
    #1;
    n_checks++;
    if (readData2 !== 32'h0000FFFF || readData1 !== 32'hFFFF0000) begin
      n_fail++;
      $display("FAIL write_bypass_r10: d1=%h d2=%h required ffff0000/0000ffff", readData1, readData2);
    end
    tick();
    idle();
    readReg1 = 5'd10;
    readReg2 = 5'd21;
    #1;
    n_checks++;
    if (readData1 !== 32'h0000FFFF || readData2 !== 32'hFFFF0000) begin
      n_fail++;
      $display("FAIL write_stored: d1=%h d2=%h required 0000ffff/ffff0000", readData1, readData2);
    end
  endtask

  task automatic test_zero_reg();
    regWrite  = 1'b1;
    writeReg  = 5'd0;
    writeData = 32'hDEADBEEF;
    resvEn    = 1'b1;
    resvReg   = 5'd0;
    readReg1  = 5'd0;
    readReg2  = 5'd0;
    #1;
    n_checks++;
    if (readData1 !== 32'h0 || readBusy1 !== 1'b0 || resvConflict !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_same_cycle: d1=%h b1=%b conf=%b required 0/0/0", readData1, readBusy1, resvConflict);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (readData2 !== 32'h0 || readBusy2 !== 1'b0 || pendingCount !== 6'd0) begin
      n_fail++;
      $display("FAIL zero_after: d2=%h b2=%b count=%0d required 0/0/0", readData2, readBusy2, pendingCount);
    end
  endtask

  task automatic test_reserve();
    resvEn   = 1'b1;
    resvReg  = 5'd5;
    readReg1 = 5'd5;
    #1;
    n_checks++;
    if (readBusy1 !== 1'b0 || resvConflict !== 1'b0) begin
      n_fail++;
      $display("FAIL resv_pre: busy1=%b conf=%b required 0/0", readBusy1, resvConflict);
    end
    tick();
    n_checks++;
    if (readBusy1 !== 1'b1 || pendingCount !== 6'd1 || resvConflict !== 1'b1) begin
      n_fail++;
      $display("FAIL resv_set: busy1=%b count=%0d conf=%b required 1/1/1", readBusy1, pendingCount, resvConflict);
    end
    tick();
    n_checks++;
    if (pendingCount !== 6'd1) begin
      n_fail++;
      $display("FAIL resv_again_count: got %0d required 1", pendingCount);
    end
    resvEn    = 1'b0;
    regWrite  = 1'b1;
    writeReg  = 5'd5;
    writeData = 32'd7;
    #1;
    n_checks++;
    if (readBusy1 !== 1'b0 || readData1 !== 32'd7 || resvConflict !== 1'b0) begin
      n_fail++;
      $display("FAIL resv_release_bypass: busy1=%b d1=%h conf=%b required 0/7/0", readBusy1, readData1, resvConflict);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (readBusy1 !== 1'b0 || readData1 !== 32'd7 || pendingCount !== 6'd0) begin
      n_fail++;
      $display("FAIL resv_released: busy1=%b d1=%h count=%0d required 0/7/0", readBusy1, readData1, pendingCount);
    end
  endtask

  task automatic test_same_edge();
    resvEn    = 1'b1;
    resvReg   = 5'd8;
    regWrite  = 1'b1;
    writeReg  = 5'd8;
    writeData = 32'h55;
    readReg2  = 5'd8;
    tick();
    idle();
    #1;
    n_checks++;
    if (readData2 !== 32'h55 || readBusy2 !== 1'b1 || pendingCount !== 6'd1) begin
      n_fail++;
      $display("FAIL same_edge: d2=%h b2=%b count=%0d required 55/1/1", readData2, readBusy2, pendingCount);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pat;
    for (int i = 11; i < 15; i++) begin
      regWrite  = 1'b1;
      writeReg  = 5'(i);
      writeData = 32'hA5000000 | 32'(i);
      tick();
    end
    idle();
    for (int i = 11; i < 15; i++) begin
      readReg1 = 5'(i);
      pat = 32'hA5000000 | 32'(i);
      #1;
      n_checks++;
      if (readData1 !== pat || readBusy1 !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_r%0d: d1=%h b1=%b required %h/0", i, readData1, readBusy1, pat);
      end
    end
  endtask

  task automatic test_reset_mid();
    resvEn  = 1'b1;
    resvReg = 5'd3;
    tick();
    resvReg = 5'd4;
    tick();
    idle();
    readReg1 = 5'd3;
    readReg2 = 5'd4;
    #1;
    n_checks++;
    if (pendingCount !== 6'd3 || readBusy1 !== 1'b1 || readBusy2 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: count=%0d b1=%b b2=%b required 3/1/1", pendingCount, readBusy1, readBusy2);
    end
    reset_n   = 1'b0;
    resvEn    = 1'b1;
    resvReg   = 5'd3;
    regWrite  = 1'b1;
    writeReg  = 5'd9;
    writeData = 32'h12345678;
    readReg1  = 5'd9;
    readReg2  = 5'd8;
    #1;
    n_checks++;
    if (readData1 !== 32'h0 || readData2 !== 32'h0 || readBusy2 !== 1'b0 || resvConflict !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_forced: d1=%h d2=%h b2=%b conf=%b required 0/0/0/0",
               readData1, readData2, readBusy2, resvConflict);
    end
    tick();
    reset_n = 1'b1;
    idle();
    #1;
    n_checks++;
    if (pendingCount !== 6'd0 || readData1 !== 32'h0 || readData2 !== 32'h0 || readBusy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_after: count=%0d d1=%h d2=%h b2=%b required 0/0/0/0",
               pendingCount, readData1, readData2, readBusy2);
    end
    readReg1 = 5'd3;
    readReg2 = 5'd21;
    #1;
    n_checks++;
    if (readBusy1 !== 1'b0 || readData2 !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_cleared: b1=%b d2=%h required 0/0", readBusy1, readData2);
    end
  endtask

  initial begin
    readReg1 = '0;
    readReg2 = '0;
    test_reset();
    test_write();
    test_zero_reg();
    test_reserve();
    test_same_edge();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
